dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_if.sv | 28 ++
 rtl/dcache_ctrl.sv | 80 ++++++++
 tb/tb_dcache_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// dcache_if: CPU request/response, cache RAM line port and memory line port of dcache_ctrl.
interface dcache_if;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_wstrb;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         bram_we;
  logic [9:0]   bram_addr;
  logic [531:0] bram_wdata, bram_rdata;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [511:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [511:0] mem_resp_rdata;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, bram_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, bram_we, bram_addr, bram_wdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, bram_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata, bram_we, bram_addr, bram_wdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller, 1024 x 64-byte lines held
// in an external RAM, with write-back and fill over a line-wide memory port.
module dcache_ctrl (
  input logic clk,
  input logic rstn,
  dcache_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;
  state_t r_state, w_next;
  logic r_we, r_resp_valid;
  logic [31:2] r_addr;
  logic [31:0] r_wdata, r_resp_rdata, w_word;
  logic [3:0] r_wstrb;
  logic [15:0] r_vtag;
  logic [511:0] r_vdata, w_base, w_merged;
  logic [8:0] w_bit;
  logic w_hit, w_done;
  assign w_bit = {r_addr[5:2], 5'd0};
  assign w_hit = bus.bram_rdata[531] && bus.bram_rdata[527:512] == r_addr[31:16];
  assign w_base = r_state == FILL_WAIT ? bus.mem_resp_rdata : bus.bram_rdata[511:0];
  assign w_word = w_base[w_bit +: 32];
  assign w_done = (r_state == LOOKUP && w_hit) || (r_state == FILL_WAIT && bus.mem_resp_valid);
  always_comb begin
    w_merged = w_base;
    for (int b = 0; b < 4; b++)
      if (r_wstrb[b]) w_merged[{r_addr[5:2], b[1:0], 3'd0} +: 8] = r_wdata[b*8 +: 8];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.req_valid) w_next = LOOKUP;
      LOOKUP:    w_next = w_hit ? IDLE : (bus.bram_rdata[531] && bus.bram_rdata[530]) ? WB_REQ : FILL_REQ;
      WB_REQ:    if (bus.mem_req_ready) w_next = WB_WAIT;
      WB_WAIT:   if (bus.mem_resp_valid) w_next = FILL_REQ;
      FILL_REQ:  if (bus.mem_req_ready) w_next = FILL_WAIT;
      FILL_WAIT: if (bus.mem_resp_valid) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  // Every output is gated by rstn so reset forces it low without waiting for a clock.
  assign bus.req_ready = rstn && r_state == IDLE;
  assign bus.bram_we = rstn && ((r_state == LOOKUP && w_hit && r_we) ||
                                (r_state == FILL_WAIT && bus.mem_resp_valid));
  assign bus.bram_addr = !rstn ? '0 : r_state == IDLE ? bus.req_addr[15:6] : r_addr[15:6];
  assign bus.bram_wdata = bus.bram_we ? {1'b1, r_state == FILL_WAIT ? r_we : 1'b1, 2'b0,
                                         r_addr[31:16], r_we ? w_merged : w_base} : '0;
  assign bus.mem_req_valid = rstn && (r_state == WB_REQ || r_state == FILL_REQ);
  assign bus.mem_req_we = rstn && r_state == WB_REQ;
  assign bus.mem_req_addr = !rstn ? '0 : r_state == WB_REQ ? {r_vtag, r_addr[15:6], 6'b0} :
                            r_state == FILL_REQ ? {r_addr[31:6], 6'b0} : '0;
  assign bus.mem_req_wdata = rstn && r_state == WB_REQ ? r_vdata : '0;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= IDLE;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_vtag <= '0;
      r_vdata <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_resp_valid <= w_done;
      r_resp_rdata <= w_done && !r_we ? w_word : '0;
      if (r_state == IDLE && bus.req_valid) begin
        r_we <= bus.req_we;
        r_addr <= bus.req_addr[31:2];
        r_wdata <= bus.req_wdata;
        r_wstrb <= bus.req_wstrb;
      end
      if (r_state == LOOKUP) begin
        r_vtag <= bus.bram_rdata[527:512];
        r_vdata <= bus.bram_rdata[511:0];
      end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed vectors plus random traffic against a flat word-memory and
// tag-directory reference, with behavioural cache RAM and line memory.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rstn;
  int checks = 0, errors = 0;
  dcache_if bus();
  dcache_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  logic [531:0] bram [1024] = '{default: '0};
  int bram_we_cnt = 0;
  always @(posedge clk) begin
    if (bus.bram_we) begin
      bram[bus.bram_addr] <= bus.bram_wdata;
      bram_we_cnt <= bram_we_cnt + 1;
    end
    bus.bram_rdata <= bram[bus.bram_addr];
  end
  logic [31:0] mem_words [logic [29:0]];
  logic [31:0] arch [logic [29:0]];
  bit rv [1024];
  bit rdr [1024];
  logic [15:0] rt [1024];
  logic [31:0] o_rd, o_wb_addr, o_fill_addr;
  logic [511:0] o_wb_data;
  bit o_done, o_miss, o_wb;
  int o_lat;
  typedef struct {
    logic we; logic [31:0] addr, wdata; logic [3:0] wstrb; int rdy;
    logic [31:0] exp_rd; bit exp_miss, exp_wb;
  } vec_t;
  vec_t vt [5];
  function automatic logic [31:0] init_word(input logic [29:0] i);
    return {2'b0, i} * 32'h9E3779B1 + 32'h01234567;
  endfunction
  function automatic logic [31:0] arch_rd(input logic [29:0] i);
    return arch.exists(i) ? arch[i] : init_word(i);
  endfunction
  function automatic logic [511:0] fill_line(input logic [31:0] a);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) begin
      logic [29:0] k;
      k = a[31:2] + 30'(w);
      d[w*32 +: 32] = mem_words.exists(k) ? mem_words[k] : init_word(k);
    end
    return d;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int rdy, input bit hold);
    logic [9:0] ix;
    logic [15:0] tg;
    bit e_miss, e_wb, cwe, rrn, rvn;
    logic [31:0] e_wba, e_rd, ca, old;
    logic [511:0] cwd, cfill, rdn;
    int we0, ms, cnt, rc;
    ix = addr[15:6];
    tg = addr[31:16];
    e_miss = !(rv[ix] && rt[ix] == tg);
    e_wb = e_miss && rv[ix] && rdr[ix];
    e_wba = {rt[ix], ix, 6'b0};
    e_rd = we ? 32'h0 : arch_rd(addr[31:2]);
    we0 = bram_we_cnt;
    ms = 0; cnt = 0; rc = 0; cwe = 0; ca = '0; cwd = '0; cfill = '0;
    o_done = 0; o_miss = 0; o_wb = 0; o_lat = 0; o_rd = '0;
    @(negedge clk);
    chk("resp_one_cycle", {63'b0, bus.resp_valid}, 64'd0);
    chk("req_ready_idle", {63'b0, bus.req_ready}, 64'd1);
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd; bus.req_wstrb = ws;
    for (int n = 1; n <= 400 && !o_done; n++) begin
      @(negedge clk);
      rrn = 0; rvn = 0; rdn = '0;
      if (bus.resp_valid) begin
        o_rd = bus.resp_rdata; o_lat = n; o_done = 1;
        chk("ready_with_resp", {63'b0, bus.req_ready}, 64'd1);
      end else if (ms == 2) begin
        chk("no_req_in_wait", {63'b0, bus.mem_req_valid}, 64'd0);
        if (hold && !cwe) o_done = 1;
        else begin
          rc--;
          if (rc == 0) begin
            rvn = 1; rdn = cwe ? {16{32'hBAD0BAD0}} : cfill; ms = 0;
          end
        end
      end else begin
        if (ms == 0 && bus.mem_req_valid) begin
          ca = bus.mem_req_addr; cwe = bus.mem_req_we; cwd = bus.mem_req_wdata;
          cnt = rdy < 0 ? int'($urandom_range(0, 3)) : rdy; ms = 1;
        end else if (ms == 1)
          chk("mem_req_stable", {29'b0, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr,
              bus.mem_req_wdata == cwd}, {29'b0, 1'b1, cwe, ca, 1'b1});
        if (ms == 1) begin
          if (cnt == 0) begin
            rrn = 1; ms = 2; rc = int'($urandom_range(1, 3));
            if (cwe) begin
              o_wb = 1; o_wb_addr = ca; o_wb_data = cwd;
              for (int w = 0; w < 16; w++) mem_words[ca[31:2] + 30'(w)] = cwd[w*32 +: 32];
            end else begin
              o_miss = 1; o_fill_addr = ca; cfill = fill_line(ca);
            end
          end else cnt--;
        end
      end
      bus.req_valid = 0; bus.mem_req_ready = rrn; bus.mem_resp_valid = rvn; bus.mem_resp_rdata = rdn;
    end
    if (!o_done) chk("timeout", 64'd0, 64'd1);
    if (hold) return;
    chk("rdata", {32'b0, o_rd}, {32'b0, e_rd});
    chk("miss", {63'b0, o_miss}, {63'b0, e_miss});
    chk("writeback", {63'b0, o_wb}, {63'b0, e_wb});
    if (e_wb) chk("wb_addr", {32'b0, o_wb_addr}, {32'b0, e_wba});
    if (e_miss) chk("fill_addr", {32'b0, o_fill_addr}, {32'b0, addr[31:6], 6'b0});
    else chk("hit_latency", 64'(o_lat), 64'd2);
    chk("bram_we_count", 64'(bram_we_cnt - we0), {63'b0, we | e_miss});
    if (e_miss) begin rv[ix] = 1; rt[ix] = tg; rdr[ix] = we; end
    else if (we) rdr[ix] = 1;
    if (we) begin
      old = arch_rd(addr[31:2]);
      for (int b = 0; b < 4; b++) if (ws[b]) old[b*8 +: 8] = wd[b*8 +: 8];
      arch[addr[31:2]] = old;
    end
  endtask
  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++)
      run_op(1'($urandom_range(0, 1)),
             {16'($urandom_range(1, 4)), 10'($urandom_range(0, 3)), 4'($urandom), 2'b0},
             $urandom, 4'($urandom), -1, 0);
  endtask
  initial begin
    logic [531:0] saved;
    int we0;
    rstn = 0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_rdata = '0;
    mem_words[30'h4010] = 32'hDEADBEEF; arch[30'h4010] = 32'hDEADBEEF;
    mem_words[30'h4011] = 32'hCAFEF00D; arch[30'h4011] = 32'hCAFEF00D;
    vt[0] = '{1'b0, 32'h00010040, 32'h0, 4'h0, -1, 32'hDEADBEEF, 1'b1, 1'b0};
    vt[1] = '{1'b0, 32'h00010044, 32'h0, 4'h0, -1, 32'hCAFEF00D, 1'b0, 1'b0};
    vt[2] = '{1'b1, 32'h00010040, 32'h11223344, 4'b0011, -1, 32'h0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 32'h00010040, 32'h0, 4'h0, -1, 32'hDEAD3344, 1'b0, 1'b0};
    vt[4] = '{1'b0, 32'h00020040, 32'h0, 4'h0, 5, init_word(30'h8010), 1'b1, 1'b1};
    @(negedge clk);
    chk("rst_outputs", {58'b0, bus.req_ready, bus.resp_valid, bus.bram_we, bus.mem_req_valid,
        bus.mem_req_addr == 0, bus.bram_addr == 0}, 64'b11);
    @(negedge clk);
    rstn = 1;
    #1 chk("ready_after_reset", {63'b0, bus.req_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      run_op(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].rdy, 0);
      chk("vec_rdata", {32'b0, o_rd}, {32'b0, vt[i].exp_rd});
      chk("vec_miss", {63'b0, o_miss}, {63'b0, vt[i].exp_miss});
      chk("vec_wb", {63'b0, o_wb}, {63'b0, vt[i].exp_wb});
      if (i == 0) chk("line1_fill_meta", {44'b0, bram[1][531:512]}, 64'h80001);
      if (i == 2) chk("line1_store", {28'b0, bram[1][531:528], bram[1][31:0]}, {28'b0, 4'b1100, 32'hDEAD3344});
      if (i == 4) begin
        chk("vec_wb_addr", {32'b0, o_wb_addr}, 64'h00010040);
        chk("vec_wb_data", o_wb_data[63:0], {32'hCAFEF00D, 32'hDEAD3344});
        chk("vec_fill_addr", {32'b0, o_fill_addr}, 64'h00020040);
      end
    end
    rand_ops(250);
    saved = bram[2];
    run_op(1'b0, 32'h00300080, 32'h0, 4'h0, -1, 1);
    we0 = bram_we_cnt;
    @(negedge clk);
    rstn = 0;
    #1 chk("mid_rst_outputs", {60'b0, bus.req_ready, bus.resp_valid, bus.bram_we, bus.mem_req_valid}, 64'd0);
    @(negedge clk);
    rstn = 1; bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_resp_rdata = {16{32'h55AA55AA}};
    #1 chk("ready_after_mid_rst", {63'b0, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.mem_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("no_resp_after_abort", {63'b0, bus.resp_valid}, 64'd0);
      @(negedge clk);
    end
    chk("no_bram_we_after_abort", 64'(bram_we_cnt - we0), 64'd0);
    chk("line2_untouched", {63'b0, bram[2] == saved}, 64'd1);
    rand_ops(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
